// File: rtl/fibonacci_core_if.sv
// Start/ready/done handshake and result bus for fibonacci_core.
interface fibonacci_core_if #(
  parameter int N_W = 5,
  parameter int F_W = 20
);
  logic           start;
  logic [N_W-1:0] i;
  logic           ready;
  logic           done_tick;
  logic [F_W-1:0] f;

  modport master (
    output start,
    output i,
    input  ready,
    input  done_tick,
    input  f
  );

  modport slave (
    input  start,
    input  i,
    output ready,
    output done_tick,
    output f
  );
endinterface

// File: rtl/fibonacci_core.sv
// Iterative Fibonacci: latches i on start, adds once per clock, pulses done_tick with fib(i) on f.
// Latency: max(i,1) OP cycles then one DONE cycle; start is only accepted while ready is high.
module fibonacci_core #(
  parameter int N_W = 5,
  parameter int F_W = 20
) (
  input  logic           clk,
  input  logic           rst,
  fibonacci_core_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [F_W-1:0] t0;
  logic [F_W-1:0] t1;
  logic [N_W-1:0] n;
  logic           ready_q;
  logic           done_q;

  // ready/done are registered alongside state so they stay pure state decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      t0      <= '0;
      t1      <= '0;
      n       <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            t0      <= '0;
            t1      <= F_W'(1);
            n       <= bus.i;
            state   <= OP;
            ready_q <= 1'b0;
          end
        end
        OP: begin
          if (n == '0) begin
            t1     <= '0;
            state  <= DONE;
            done_q <= 1'b1;
          end else if (n == N_W'(1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            t1 <= t1 + t0;
            t0 <= t1;
            n  <= n - N_W'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done_tick = done_q;
  assign bus.f         = t1;

endmodule

// File: tb/tb_fibonacci_core.sv
// Directed and randomized checks of fibonacci_core against an arithmetic Fibonacci model.
module tb_fibonacci_core;
  localparam int N_W = 5;
  localparam int F_W = 20;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  fibonacci_core_if #(.N_W(N_W), .F_W(F_W)) bus ();

  fibonacci_core #(.N_W(N_W), .F_W(F_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [F_W-1:0] fib_ref(input int idx);
    logic [F_W-1:0] a, b, s;
    a = '0;
    b = F_W'(1);
    for (int k = 0; k < idx; k++) begin
      s = a + b;
      a = b;
      b = s;
    end
    return a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_chk(input int idx, input logic [F_W-1:0] exp);
    int c;
    int lat;
    lat = ((idx == 0) ? 1 : idx) + 1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.i     = N_W'(idx);
    @(negedge clk);
    bus.start = 1'b0;
    bus.i     = N_W'($urandom);
    check("busy", 32'(bus.ready), 32'd0);
    c = 1;
    while (!bus.done_tick && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("latency", 32'(c), 32'(lat));
    check("f_in_done", 32'(bus.f), 32'(exp));
    check("ready_in_done", 32'(bus.ready), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done_tick), 32'd0);
    check("ready_after", 32'(bus.ready), 32'd1);
    check("f_after", 32'(bus.f), 32'(exp));
  endtask

  task automatic run_one(input int idx);
    run_chk(idx, fib_ref(idx));
  endtask

  initial begin
    int done_cyc[$];
    logic [F_W-1:0] done_f[$];
    int exp_cyc[3];
    logic [F_W-1:0] exp_f[3];
    int saw_done;
    int c;

    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.i     = '0;

    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done_tick), 32'd0);
    check("rst_f", 32'(bus.f), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(bus.ready), 32'd1);
    check("idle_done", 32'(bus.done_tick), 32'd0);
    check("idle_f", 32'(bus.f), 32'd0);

    run_chk(10, 20'd55);
    repeat (5) @(negedge clk);
    check("f_hold_idle", 32'(bus.f), 32'd55);

    run_chk(0, 20'd0);
    run_chk(1, 20'd1);
    run_chk(2, 20'd1);
    run_chk(30, 20'd832040);
    run_chk(31, 20'd297693);

    for (int r = 0; r < 20; r++) begin
      run_one(int'($urandom_range(0, 31)));
    end

    // Continuous start: pulses 12 cycles apart for i=10; i switches to 5
    // during the second run, so the second result is still 55 and the third
    // run (sampled with i=5) ends 7 cycles later.
    exp_cyc[0] = 11; exp_f[0] = 20'd55;
    exp_cyc[1] = 23; exp_f[1] = 20'd55;
    exp_cyc[2] = 30; exp_f[2] = 20'd5;
    @(negedge clk);
    bus.start = 1'b1;
    bus.i     = N_W'(10);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 20) bus.i = N_W'(5);
      if (bus.done_tick) begin
        done_cyc.push_back(k);
        done_f.push_back(bus.f);
      end
    end
    bus.start = 1'b0;
    check("hold_pulses", 32'(done_cyc.size()), 32'd3);
    for (int p = 0; p < 3; p++) begin
      if (p < done_cyc.size()) begin
        check("hold_cycle", 32'(done_cyc[p]), 32'(exp_cyc[p]));
        check("hold_f", 32'(done_f[p]), 32'(exp_f[p]));
      end
    end
    c = 0;
    while (!bus.ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("hold_back_idle", 32'(bus.ready), 32'd1);

    // Reset during OP aborts immediately.
    @(negedge clk);
    bus.start = 1'b1;
    bus.i     = N_W'(20);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", 32'(bus.ready), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_done", 32'(bus.done_tick), 32'd0);
    check("abort_f", 32'(bus.f), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done_tick) saw_done = 1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_f_hold", 32'(bus.f), 32'd0);

    run_chk(7, 20'd13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
